// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: bit timing, FSM
// state encodings (same encoding the receiver uses) and the line-level helper.
package uart_tx_buffered_pkg;

    localparam int TICKS_PER_BIT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Level the tx pin takes while the FSM sits in state st.
    function automatic logic line_level(tx_state_e st, logic data_bit);
        case (st)
            ST_START: return 1'b0;
            ST_DATA:  return data_bit;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
// A write while full is accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              wr_ok, rd_ok;

    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
                2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = count_q[ADDR_W];
    assign empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter: FIFO-buffered bytes shifted out as start/data/stop frames,
// paced by a 16x baud tick. FSMD with registered state and combinational next state.
module uart_tx_buffered #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int ADDR_W  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       wr_en,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done_tick
);
    import uart_tx_buffered_pkg::*;

    localparam logic [4:0] S_BIT_LAST  = 5'(TICKS_PER_BIT - 1);
    localparam logic [4:0] S_STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST      = 3'(DBIT - 1);

    tx_state_e  state_q, state_d;
    logic [4:0] s_q, s_d;
    logic [2:0] n_q, n_d;
    logic [7:0] b_q, b_d;
    logic       tx_q, tx_d;
    logic       fifo_rd;
    logic [7:0] fifo_dout;

    uart_tx_fifo #(
        .DATA_W (8),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (wr_en),
        .rd_en (fifo_rd),
        .din   (din),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        fifo_rd      = 1'b0;
        tx_done_tick = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    fifo_rd = 1'b1;
                    b_d     = fifo_dout;
                    s_d     = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = ST_DATA;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d = '0;
                        b_d = {1'b0, b_q[7:1]};
                        if (n_q == N_LAST) state_d = ST_STOP;
                        else               n_d     = n_q + 3'd1;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        tx_done_tick = 1'b1;
                        // Chain straight into the next frame when more data waits.
                        if (!empty) begin
                            fifo_rd = 1'b1;
                            b_d     = fifo_dout;
                            s_d     = '0;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registering the next-state level keeps tx glitch-free.
        tx_d = line_level(state_d, b_d[0]);
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != ST_IDLE);

endmodule
